// File: rtl/and_result_checker_if.sv
// Bus bundle for the AND-stage result checker: run control, the sampled
// a/b/y triple with its valid/ready handshake, and the run statistics.
interface and_result_checker_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     y;
  logic [15:0]          pass_cnt;
  logic [15:0]          fail_cnt;
  logic                 err;
  logic [3*WIDTH-1:0]   first_fail;
  logic                 done;

  // Stimulus side: drives samples and start, observes the results.
  modport master (
    output start, in_valid, a, b, y,
    input  in_ready, pass_cnt, fail_cnt, err, first_fail, done
  );

  // Checker side.
  modport slave (
    input  start, in_valid, a, b, y,
    output in_ready, pass_cnt, fail_cnt, err, first_fail, done
  );
endinterface

// File: rtl/and_result_checker.sv
// Checks that y == (a & b) for NUM_TXN accepted samples per run. Each run is
// launched by a start pulse, accepted samples pass through a one-entry
// compare stage, and pass/fail counts plus the first failing triple are
// reported once the run reaches DONE.
module and_result_checker #(
  parameter int WIDTH   = 8,
  parameter int NUM_TXN = 16
) (
  input logic                 clk,
  input logic                 reset,
  and_result_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] TXN_TOTAL = 16'(NUM_TXN);

  state_t             state_q,      state_d;
  logic [15:0]        acc_cnt_q,    acc_cnt_d;
  logic               cmp_vld_q,    cmp_vld_d;
  logic [WIDTH-1:0]   cmp_a_q,      cmp_a_d;
  logic [WIDTH-1:0]   cmp_b_q,      cmp_b_d;
  logic [WIDTH-1:0]   cmp_y_q,      cmp_y_d;
  logic [15:0]        pass_cnt_q,   pass_cnt_d;
  logic [15:0]        fail_cnt_q,   fail_cnt_d;
  logic               err_q,        err_d;
  logic [3*WIDTH-1:0] first_fail_q, first_fail_d;
  logic               in_ready_q,   in_ready_d;
  logic               done_q,       done_d;

  logic               accept;
  logic               mismatch;
  logic               clear_run;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state, compare-stage and statistics update.
  always_comb begin
    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    clear_run    = 1'b0;

    accept   = bus.in_valid && in_ready_q;
    mismatch = (cmp_y_q != (cmp_a_q & cmp_b_q));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          clear_run = 1'b1;
        end
      end
      RUN: begin
        // start is ignored here; only accepted samples advance the run.
        if (accept) begin
          acc_cnt_d = acc_cnt_q + 16'd1;
          if (acc_cnt_q + 16'd1 == TXN_TOTAL) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last sample is compared on the edge that enters DONE.
        state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_d   = RUN;
          clear_run = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // One-entry compare stage: loaded on acceptance, evaluated next cycle.
    cmp_vld_d = accept;
    cmp_a_d   = accept ? bus.a : cmp_a_q;
    cmp_b_d   = accept ? bus.b : cmp_b_q;
    cmp_y_d   = accept ? bus.y : cmp_y_q;

    if (cmp_vld_q) begin
      if (mismatch) begin
        fail_cnt_d = sat_inc(fail_cnt_q);
        if (!err_q) begin
          err_d        = 1'b1;
          first_fail_d = {cmp_a_q, cmp_b_q, cmp_y_q};
        end
      end else begin
        pass_cnt_d = sat_inc(pass_cnt_q);
      end
    end

    // A new run starts from IDLE or DONE, where the compare stage is empty,
    // so clearing never races a pending update.
    if (clear_run) begin
      acc_cnt_d    = '0;
      pass_cnt_d   = '0;
      fail_cnt_d   = '0;
      err_d        = 1'b0;
      first_fail_d = '0;
    end

    in_ready_d = (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  // State, compare stage and registered outputs; reset flushes everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_cnt_q    <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      cmp_y_q      <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      err_q        <= 1'b0;
      first_fail_q <= '0;
      in_ready_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_a_q      <= cmp_a_d;
      cmp_b_q      <= cmp_b_d;
      cmp_y_q      <= cmp_y_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
      in_ready_q   <= in_ready_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.pass_cnt   = pass_cnt_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.err        = err_q;
  assign bus.first_fail = first_fail_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_and_result_checker.sv
// Randomized and directed bench for and_result_checker (WIDTH=8, NUM_TXN=4).
// A transaction-level model keeps the list of samples accepted in the
// current run and derives the expected statistics from it every cycle.
module tb_and_result_checker;

  localparam int W = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } smp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Model: run open, waiting for final compare, run finished, accepted list.
  logic m_busy = 1'b0;
  logic m_drain = 1'b0;
  logic m_done = 1'b0;
  int   m_acc = 0;
  logic last_acc = 1'b0;
  smp_t mq[$];

  and_result_checker_if #(.WIDTH(W)) bus ();

  and_result_checker #(.WIDTH(W), .NUM_TXN(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output with statistics of the samples whose compare has
  // completed (all accepted ones except one accepted on the latest edge).
  task automatic check_all();
    int n;
    logic [15:0] ep;
    logic [15:0] ef;
    logic ee;
    logic [3*W-1:0] eff;
    ep = '0; ef = '0; ee = 1'b0; eff = '0;
    n = mq.size() - (last_acc ? 1 : 0);
    for (int i = 0; i < n; i++) begin
      if (mq[i].y == (mq[i].a & mq[i].b)) ep++;
      else begin
        if (!ee) eff = {mq[i].a, mq[i].b, mq[i].y};
        ee = 1'b1;
        ef++;
      end
    end
    chk("in_ready",   64'(bus.in_ready),   64'(m_busy && !m_drain));
    chk("done",       64'(bus.done),       64'(m_done));
    chk("pass_cnt",   64'(bus.pass_cnt),   64'(ep));
    chk("fail_cnt",   64'(bus.fail_cnt),   64'(ef));
    chk("err",        64'(bus.err),        64'(ee));
    chk("first_fail", 64'(bus.first_fail), 64'(eff));
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later.
  task automatic cyc(input logic st, input logic v, input logic [W-1:0] ai,
                     input logic [W-1:0] bi, input logic [W-1:0] yi);
    logic acc;
    smp_t s;
    bus.start = st; bus.in_valid = v; bus.a = ai; bus.b = bi; bus.y = yi;
    acc = v && m_busy && !m_drain;
    @(posedge clk);
    last_acc = 1'b0;
    if (!reset) begin
      m_busy = 1'b0; m_drain = 1'b0; m_done = 1'b0; m_acc = 0;
      mq.delete();
    end else if (m_busy) begin
      if (m_drain) begin
        m_drain = 1'b0; m_busy = 1'b0; m_done = 1'b1;
      end else if (acc) begin
        s.a = ai; s.b = bi; s.y = yi;
        mq.push_back(s);
        last_acc = 1'b1;
        m_acc++;
        if (m_acc == N) m_drain = 1'b1;
      end
    end else if (st) begin
      m_busy = 1'b1; m_done = 1'b0; m_acc = 0;
      mq.delete();
    end
    #1;
    check_all();
  endtask

  task automatic good(input logic st, input logic v);
    logic [W-1:0] ra, rb;
    ra = W'($urandom); rb = W'($urandom);
    cyc(st, v, ra, rb, ra & rb);
  endtask

  task automatic bad(input logic st, input logic v);
    logic [W-1:0] ra, rb, msk;
    ra = W'($urandom); rb = W'($urandom);
    msk = W'(1 << $urandom_range(W - 1, 0));
    cyc(st, v, ra, rb, (ra & rb) ^ msk);
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.y = '0;

    // Reset, then idle with in_valid high and no start.
    reset = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    repeat (3) bad(1'b0, 1'b1);
    chk("idle_pass", 64'(bus.pass_cnt), 64'd0);

    // Clean back-to-back run; done rises one edge after the 4th acceptance.
    good(1'b1, 1'b0);
    repeat (4) good(1'b0, 1'b1);
    chk("done_early", 64'(bus.done), 64'd0);
    bad(1'b0, 1'b1);
    chk("done_late", 64'(bus.done), 64'd1);
    chk("clean_pass", 64'(bus.pass_cnt), 64'd4);
    repeat (2) bad(1'b0, 1'b1);

    // Restart from DONE; second sample is F0 & 3C != 31.
    good(1'b1, 1'b0);
    chk("restart_clr", 64'(bus.pass_cnt), 64'd0);
    good(1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'hF0, 8'h3C, 8'h31);
    repeat (2) good(1'b0, 1'b1);
    repeat (2) good(1'b0, 1'b0);
    chk("mm_pass", 64'(bus.pass_cnt), 64'd3);
    chk("mm_fail", 64'(bus.fail_cnt), 64'd1);
    chk("mm_first", 64'(bus.first_fail), 64'hF03C31);

    // Two mismatches: the first one is kept.
    good(1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'hF0, 8'h3C, 8'h31);
    good(1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'hAA, 8'h55, 8'hFF);
    good(1'b0, 1'b1);
    repeat (2) good(1'b0, 1'b0);
    chk("keep_first", 64'(bus.first_fail), 64'hF03C31);
    chk("two_fail", 64'(bus.fail_cnt), 64'd2);

    // in_valid toggling every other cycle.
    good(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) good(1'b0, (i % 2) == 0);
    chk("toggle_pass", 64'(bus.pass_cnt), 64'd4);

    // start during RUN is ignored; start in DONE clears.
    good(1'b1, 1'b0);
    repeat (2) good(1'b0, 1'b1);
    good(1'b1, 1'b1);
    good(1'b0, 1'b1);
    good(1'b1, 1'b0);
    repeat (2) good(1'b0, 1'b0);
    chk("run_start_pass", 64'(bus.pass_cnt), 64'd4);
    good(1'b1, 1'b0);
    chk("done_start_clr", 64'(bus.pass_cnt), 64'd0);

    // Reset after two acceptances with a third sample in flight.
    repeat (2) bad(1'b0, 1'b1);
    reset = 1'b0;
    bad(1'b0, 1'b1);
    reset = 1'b1;
    chk("rst_fail", 64'(bus.fail_cnt), 64'd0);
    repeat (3) bad(1'b0, 1'b1);
    good(1'b1, 1'b0);
    repeat (4) good(1'b0, 1'b1);
    repeat (2) good(1'b0, 1'b0);
    chk("post_rst_pass", 64'(bus.pass_cnt), 64'd4);

    // Random traffic: gaps, mismatches, stray starts, occasional reset.
    for (int r = 0; r < 40; r++) begin
      good(1'b1, 1'b0);
      for (int c = 0; c < 20; c++) begin
        reset = ($urandom_range(63, 0) != 0);
        if ($urandom_range(3, 0) == 0) bad($urandom_range(7, 0) == 0, $urandom_range(2, 0) != 0);
        else good($urandom_range(7, 0) == 0, $urandom_range(2, 0) != 0);
      end
      reset = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
